// File: rtl/sa_write_arbiter.sv
// Slave-side AXI4 write arbiter: grants one master's AW, tags AWID with the master index,
// steers W beats by grant order and routes B back by BID. Define ARB_ROUND_ROBIN_EN for round-robin.
module sa_write_arbiter #(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int TRANS_WR_RESP_W   = 2,
    parameter int MST_ID_W          = $clog2(MST_AMT),
    parameter int TRANS_SLV_ID_W    = MST_ID_W + TRANS_MST_ID_W
) (
    input  logic                                           ACLK_i,
    input  logic                                           ARESET_i,
    input  logic [MST_AMT-1:0][TRANS_MST_ID_W-1:0]         m_AWID_i,
    input  logic [MST_AMT-1:0][ADDR_WIDTH-1:0]             m_AWADDR_i,
    input  logic [MST_AMT-1:0][TRANS_BURST_W-1:0]          m_AWBURST_i,
    input  logic [MST_AMT-1:0][TRANS_DATA_LEN_W-1:0]       m_AWLEN_i,
    input  logic [MST_AMT-1:0][TRANS_DATA_SIZE_W-1:0]      m_AWSIZE_i,
    input  logic [MST_AMT-1:0]                             m_AWVALID_i,
    output logic [MST_AMT-1:0]                             m_AWREADY_o,
    input  logic [MST_AMT-1:0][DATA_WIDTH-1:0]             m_WDATA_i,
    input  logic [MST_AMT-1:0]                             m_WLAST_i,
    input  logic [MST_AMT-1:0]                             m_WVALID_i,
    output logic [MST_AMT-1:0]                             m_WREADY_o,
    output logic [MST_AMT-1:0][TRANS_MST_ID_W-1:0]         m_BID_o,
    output logic [MST_AMT-1:0][TRANS_WR_RESP_W-1:0]        m_BRESP_o,
    output logic [MST_AMT-1:0]                             m_BVALID_o,
    input  logic [MST_AMT-1:0]                             m_BREADY_i,
    output logic [TRANS_SLV_ID_W-1:0]                      s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                          s_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]                       s_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]                    s_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]                   s_AWSIZE_o,
    output logic                                           s_AWVALID_o,
    input  logic                                           s_AWREADY_i,
    output logic [DATA_WIDTH-1:0]                          s_WDATA_o,
    output logic                                           s_WLAST_o,
    output logic                                           s_WVALID_o,
    input  logic                                           s_WREADY_i,
    input  logic [TRANS_SLV_ID_W-1:0]                      s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]                     s_BRESP_i,
    input  logic                                           s_BVALID_i,
    output logic                                           s_BREADY_o
);

    localparam int PTR_W = $clog2(OUTSTANDING_AMT);
    localparam int CNT_W = PTR_W + 1;

    logic [TRANS_SLV_ID_W-1:0]    r_aw_id;
    logic [ADDR_WIDTH-1:0]        r_aw_addr;
    logic [TRANS_BURST_W-1:0]     r_aw_burst;
    logic [TRANS_DATA_LEN_W-1:0]  r_aw_len;
    logic [TRANS_DATA_SIZE_W-1:0] r_aw_size;
    logic                         r_aw_valid;

    logic [MST_ID_W-1:0]          r_fifo [OUTSTANDING_AMT];
    logic [PTR_W-1:0]             r_wptr;
    logic [PTR_W-1:0]             r_rptr;
    logic [CNT_W-1:0]             r_count;

    logic                         w_slot_free;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_accept;
    logic                         w_any;
    logic                         w_gnt;
    logic [MST_ID_W-1:0]          w_gnt_idx;
    logic                         w_push;
    logic                         w_pop;
    logic [MST_ID_W-1:0]          w_head;
    logic [MST_ID_W-1:0]          w_bk;
    logic                         w_bk_ok;

    assign w_full      = (r_count == CNT_W'(OUTSTANDING_AMT));
    assign w_empty     = (r_count == '0);
    assign w_slot_free = !r_aw_valid || s_AWREADY_i;
    // Full blocks grants even when a WLAST pop lands in the same cycle.
    assign w_accept    = w_slot_free && !w_full && !ARESET_i;
    assign w_any       = |m_AWVALID_i;
    assign w_gnt       = w_accept && w_any;

`ifdef ARB_ROUND_ROBIN_EN
    logic [MST_ID_W-1:0] r_rr_ptr;

    // Scan from highest offset down so the smallest offset from the pointer wins.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_gnt_idx = '0;
        for (int i = MST_AMT - 1; i >= 0; i--) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= MST_AMT) v_idx = v_idx - MST_AMT;
            if (m_AWVALID_i[v_idx]) w_gnt_idx = MST_ID_W'(v_idx);
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_rr_ptr <= '0;
        end else if (w_gnt) begin
            if (int'(w_gnt_idx) == MST_AMT - 1) r_rr_ptr <= '0;
            else                                r_rr_ptr <= w_gnt_idx + MST_ID_W'(1);
        end
    end
`else
    always_comb begin
        w_gnt_idx = '0;
        for (int i = MST_AMT - 1; i >= 0; i--) begin
            if (m_AWVALID_i[i]) w_gnt_idx = MST_ID_W'(i);
        end
    end
`endif

    // Output register: only reloads when the slot is free, so a stalled AW holds.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_burst <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_valid <= 1'b0;
        end else if (w_gnt) begin
            r_aw_id    <= {w_gnt_idx, m_AWID_i[w_gnt_idx]};
            r_aw_addr  <= m_AWADDR_i[w_gnt_idx];
            r_aw_burst <= m_AWBURST_i[w_gnt_idx];
            r_aw_len   <= m_AWLEN_i[w_gnt_idx];
            r_aw_size  <= m_AWSIZE_i[w_gnt_idx];
            r_aw_valid <= 1'b1;
        end else if (s_AWREADY_i) begin
            r_aw_valid <= 1'b0;
        end
    end

    assign s_AWID_o    = r_aw_id;
    assign s_AWADDR_o  = r_aw_addr;
    assign s_AWBURST_o = r_aw_burst;
    assign s_AWLEN_o   = r_aw_len;
    assign s_AWSIZE_o  = r_aw_size;
    assign s_AWVALID_o = r_aw_valid;

    assign w_push = w_gnt;
    assign w_pop  = s_WVALID_o && s_WREADY_i && s_WLAST_o;
    assign w_head = r_fifo[r_rptr];

    always_ff @(posedge ACLK_i) begin
        if (w_push) r_fifo[r_wptr] <= w_gnt_idx;
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                if (r_wptr == PTR_W'(OUTSTANDING_AMT - 1)) r_wptr <= '0;
                else                                        r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                if (r_rptr == PTR_W'(OUTSTANDING_AMT - 1)) r_rptr <= '0;
                else                                        r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // W beats follow the FIFO head; nothing passes before its AW was granted.
    assign s_WDATA_o  = m_WDATA_i[w_head];
    assign s_WLAST_o  = m_WLAST_i[w_head];
    assign s_WVALID_o = !w_empty && m_WVALID_i[w_head];

    assign w_bk    = s_BID_i[TRANS_SLV_ID_W-1 -: MST_ID_W];
    assign w_bk_ok = (int'(w_bk) < MST_AMT);
    // Responses tagged for a nonexistent master are sunk here.
    assign s_BREADY_o = w_bk_ok ? m_BREADY_i[w_bk] : 1'b1;

    for (genvar g = 0; g < MST_AMT; g++) begin : g_lane
        assign m_AWREADY_o[g] = w_gnt && (w_gnt_idx == MST_ID_W'(g));
        assign m_WREADY_o[g]  = !w_empty && s_WREADY_i && (w_head == MST_ID_W'(g));
        assign m_BVALID_o[g]  = s_BVALID_i && w_bk_ok && (w_bk == MST_ID_W'(g));
        assign m_BID_o[g]     = s_BID_i[TRANS_MST_ID_W-1:0];
        assign m_BRESP_o[g]   = s_BRESP_i;
    end

endmodule

// File: doc/sa_write_arbiter.md
# sa_write_arbiter

Slave-side write arbitration stage for one AXI4 slave port of the interconnect. Takes the per-slave AW/W/B lanes that every master's write dispatcher fans out, grants one master's write address at a time, and forwards it to the slave through an output register with the master index prepended to AWID. It records grant order in a FIFO that steers W beats from the matching master until WLAST, and routes B responses back by the BID master-index field.

## Interface
Parameters:
- MST_AMT, 2, number of masters (dispatchers) competing for this slave; ≥2
- OUTSTANDING_AMT, 8, grant FIFO depth (AW accepted, WLAST not yet passed)
- DATA_WIDTH, 32, W data width
- ADDR_WIDTH, 32, AW address width
- TRANS_MST_ID_W, 5, master-side transaction ID width
- TRANS_BURST_W, 2 / TRANS_DATA_LEN_W, 3 / TRANS_DATA_SIZE_W, 3 / TRANS_WR_RESP_W, 2, field widths
- MST_ID_W, $clog2(MST_AMT), master index width
- TRANS_SLV_ID_W, MST_ID_W+TRANS_MST_ID_W, slave-side ID width

Ports (m_* buses are packed, master i at slice i):
- ACLK_i  in  1  clock
- ARESET_i  in  1  synchronous, active-high reset
- m_AWID_i / m_AWADDR_i / m_AWBURST_i / m_AWLEN_i / m_AWSIZE_i  in  field width×MST_AMT  AW payload per master
- m_AWVALID_i  in  MST_AMT  / m_AWREADY_o  out  MST_AMT
- m_WDATA_i  in  DATA_WIDTH×MST_AMT; m_WLAST_i, m_WVALID_i  in  MST_AMT; m_WREADY_o  out  MST_AMT
- m_BID_o  out  TRANS_MST_ID_W×MST_AMT; m_BRESP_o  out  TRANS_WR_RESP_W×MST_AMT; m_BVALID_o  out  MST_AMT; m_BREADY_i  in  MST_AMT
- s_AWID_o  out  TRANS_SLV_ID_W; s_AWADDR_o/s_AWBURST_o/s_AWLEN_o/s_AWSIZE_o  out  field widths; s_AWVALID_o  out  1; s_AWREADY_i  in  1
- s_WDATA_o  out  DATA_WIDTH; s_WLAST_o, s_WVALID_o  out  1; s_WREADY_i  in  1
- s_BID_i  in  TRANS_SLV_ID_W; s_BRESP_i  in  TRANS_WR_RESP_W; s_BVALID_i  in  1; s_BREADY_o  out  1

## Operation
- AW accept condition: `slot_free = !s_AWVALID_o || s_AWREADY_i`, and FIFO not full, and not in reset.
- When the accept condition holds, the arbiter picks one requester g among m_AWVALID_i and asserts m_AWREADY_o[g] only. m_AWREADY_o is one-hot or zero.
- On the grant handshake:
  - the output register loads s_AWID_o={g, m_AWID_i[g]} plus the payload, and s_AWVALID_o=1;
  - g is pushed into the grant FIFO.
- Output register holds its value while s_AWVALID_o && !s_AWREADY_i.
- Grant FIFO: width MST_ID_W, depth OUTSTANDING_AMT, count width $clog2(OUTSTANDING_AMT)+1.
  - Push = AW grant handshake. Pop = s_WVALID_o && s_WREADY_i && s_WLAST_o.
  - Full blocks grants even if a pop happens in the same cycle.
  - Pointers wrap modulo depth.
- W steering (combinational from FIFO head h):
  - FIFO non-empty: s_W* = m_W*[h] and m_WREADY_o[h] = s_WREADY_i; all other m_WREADY_o bits are 0.
  - FIFO empty: s_WVALID_o=0 and all m_WREADY_o=0. W beats never precede their own AW grant.
- B routing (combinational), with k = s_BID_i[TRANS_SLV_ID_W-1 -: MST_ID_W]:
  - m_BVALID_o[k] = s_BVALID_i; all other bits 0.
  - Every lane of m_BID_o carries s_BID_i[TRANS_MST_ID_W-1:0], and every lane of m_BRESP_o carries s_BRESP_i.
  - s_BREADY_o = m_BREADY_i[k].
  - If k ≥ MST_AMT: no m_BVALID_o is asserted, s_BREADY_o=1, and the response is dropped.

## Timing
- Reset values: s_AWVALID_o=0; s_AW* payload registers all 0; FIFO empty (count 0); round-robin pointer 0; all m_AWREADY_o, m_WREADY_o and m_BVALID_o = 0.
- Reset mid-operation: the pending AW and all grant FIFO entries are discarded. Upstream and downstream are reset together.
- AW latency: 1 cycle from the m-side handshake to s_AWVALID_o. Throughput is 1 AW/cycle while the slave keeps s_AWREADY_i=1.
- First W after a grant into an empty FIFO: forwarded from the cycle after the push (W steering uses the registered FIFO state).
- WLAST pop and a new push in the same cycle: count stays unchanged and the head advances.
- W and B paths: zero latency, no storage.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. After a grant to g, priority order is g+1, g+2, … mod MST_AMT.
  - The pointer updates only on a grant handshake.
- Not defined:
  - Fixed priority: lowest requesting index wins.
  - No pointer register.

## Test plan
- Reset, then ARESET_i held 1 for 2 cycles while masters 0 and 1 drive m_AWVALID_i=11 -> all m_AWREADY_o=00, s_AWVALID_o=0, FIFO count 0.
- Master 1 alone, AWID=5'h3, AWADDR=32'h4000_0010, AWLEN=3, s_AWREADY_i=1 -> m_AWREADY_o=10. Next cycle s_AWVALID_o=1 with s_AWID_o=6'h23. Then 4 W beats from master 1 pass, and WLAST pops the FIFO to empty.
- Both masters request continuously with s_AWREADY_i=1 -> with ARB_ROUND_ROBIN_EN the grants alternate 0,1,0,1. Without the macro, master 0 is granted every cycle.
- s_WREADY_i=0 with 8 single-beat AWs granted -> FIFO full, m_AWREADY_o=00 on the 9th request. One WLAST handshake then re-enables a grant one cycle later.
- s_AWREADY_i=0 for 3 cycles -> s_AW* stable, s_AWVALID_o=1, m_AWREADY_o=00 until s_AWREADY_i rises.
- B routing:
  - s_BID_i=6'h25, s_BVALID_i=1 -> m_BVALID_o=10, master 1 lane BID=5'h05, s_BREADY_o follows m_BREADY_i[1].
  - With MST_AMT=3, s_BID_i index 3 -> s_BREADY_o=1 and m_BVALID_o=000.
